rx_engine: RTL and testbench
============================

RX_ENGINE -- requirements
Module: rx_engine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (all state updates on rising edge) and rst.
REQ-002 clk  in  1  system clock, 100 MHz.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 rx  in  1  serial line, idle high, LSB first.
REQ-005 eight  in  1  1 = 8 data bits, 0 = 7 data bits.
REQ-006 p_en  in  1  1 = parity bit follows data.
REQ-007 ohel  in  1  parity sense: 1 = odd, 0 = even.
REQ-008 baud  in  4  bit-rate select (REQ-012).
REQ-009 clr  in  1  one-cycle pulse; consumer has read data_out.
REQ-010 data_out  out  8  received byte; bit7 = 0 in 7-bit mode.
REQ-011 rxrdy, perr, ferr, ovf  out  1 each  frame ready, parity error, framing error, overflow.

Function
REQ-012 Bit time k (clocks) SHALL be, for baud 0..B: 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109; codes C..F SHALL use 109.
REQ-013 A 19-bit bit-time counter SHALL count k-1 down to 0 per bit period; the half-bit interval SHALL be k/2 (integer divide).
REQ-014 States SHALL be IDLE, START, DATA, DONE; reset state IDLE.
REQ-015 IDLE -> START on rx sampled 0; START waits k/2 clocks then samples rx.
REQ-016 START sample 1 (false start) -> IDLE, no flags changed; sample 0 -> DATA with counter reloaded to k.
REQ-017 DATA SHALL sample rx every k clocks, shifting right into a 10-bit register; bits after start N = 7 + eight + p_en + 1 (8..10).
REQ-018 After the N-th sample (stop bit) DATA -> DONE; DONE SHALL last exactly one clock, then -> IDLE, with rx low in IDLE re-arming START next clock.
REQ-019 On the DONE clock: data_out, perr, ferr load and rxrdy <= 1; visible one clock after stop-bit sample.
REQ-020 data_out = eight ? d[7:0] : {1'b0, d[6:0]}.
REQ-021 perr = p_en & ((XOR of received data bits ^ parity bit) != ohel); perr = 0 when p_en = 0.
REQ-022 ferr = 1 when sampled stop bit = 0; data_out still delivered.
REQ-023 ovf SHALL set in DONE if rxrdy is already 1 and clr is not asserted that clock; data_out is overwritten by the new frame.
REQ-024 clr SHALL clear rxrdy, perr, ferr, ovf next clock; clr coincident with DONE: DONE wins (rxrdy = 1, new perr/ferr), ovf not set.
REQ-025 eight, p_en, ohel, baud SHALL be sampled only in IDLE; changes mid-frame do not affect the current frame.

Reset
REQ-026 rst SHALL force IDLE, counters 0, shift register 0, data_out 8'h00, rxrdy/perr/ferr/ovf 0, synchronizer flops 1.
REQ-027 rst mid-frame SHALL abandon the frame with no flag or data update; rst has priority over clr and DONE.

Configuration
REQ-028 Macro RX_SYNC_EN defined: rx SHALL pass a two-flop synchronizer (reset to 1) before use, adding 2 clocks to all latencies.
REQ-029 RX_SYNC_EN undefined: rx SHALL be used directly; all other behaviour identical.

Verification
REQ-030 baud=B, eight=1, p_en=1, ohel=0, frame 0x65 parity 0 stop 1 -> data_out=8'h65, rxrdy=1, perr=0, ferr=0, 10*109+55 clks after start edge (+/-2).
REQ-031 baud=B, eight=0, p_en=0, 7-bit 0x65 -> data_out=8'h65, perr=0; then clr pulse -> rxrdy=0 next clock.
REQ-032 eight=1, p_en=1, ohel=1, 0x65 with parity 0 -> perr=1; 0x3C with stop 0 -> ferr=1, data_out=8'h3C.
REQ-033 baud=B, rx low 20 clocks in IDLE -> back to IDLE, rxrdy stays 0, no flags.
REQ-034 two frames 0x11, 0x22 without clr -> ovf=1, data_out=8'h22; clr on second DONE clock -> ovf=0, rxrdy=1.
REQ-035 rst during DATA of 0x55 -> all outputs 0; next frame 0xA5 received correctly.

Source files
------------

// File: rtl/rx_engine.sv
// Serial frame receiver: 7/8 data bits, optional parity, one stop bit.
// Define RX_SYNC_EN to pass rx through a two-flop synchronizer first.
module rx_engine (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       eight,
    input  logic       p_en,
    input  logic       ohel,
    input  logic [3:0] baud,
    input  logic       clr,
    output logic [7:0] data_out,
    output logic       rxrdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

    state_t      state, state_d;
    logic        rx_s;
    logic [18:0] k_sel, k_q, cnt;
    logic        eight_q, pen_q, ohel_q;
    logic [3:0]  bits, n_bits;
    logic [9:0]  sr;
    logic [8:0]  frame;
    logic [7:0]  dbits;
    logic        par_bit, perr_d, cnt_zero, last;

`ifdef RX_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end

    assign rx_s = sync[1];
`else
    assign rx_s = rx;
`endif

    always_comb begin
        case (baud)
            4'h0:    k_sel = 19'd333333;
            4'h1:    k_sel = 19'd83333;
            4'h2:    k_sel = 19'd41667;
            4'h3:    k_sel = 19'd20833;
            4'h4:    k_sel = 19'd10417;
            4'h5:    k_sel = 19'd5208;
            4'h6:    k_sel = 19'd2604;
            4'h7:    k_sel = 19'd1736;
            4'h8:    k_sel = 19'd868;
            4'h9:    k_sel = 19'd434;
            4'hA:    k_sel = 19'd217;
            default: k_sel = 19'd109;
        endcase
    end

    // Received bits land MSB-aligned in sr; shift them down to bit 0.
    assign n_bits   = 4'd8 + {3'b0, eight_q} + {3'b0, pen_q};
    assign frame    = 9'(sr >> (4'd10 - n_bits));
    assign dbits    = eight_q ? frame[7:0] : {1'b0, frame[6:0]};
    assign par_bit  = eight_q ? frame[8] : frame[7];
    assign perr_d   = pen_q & ((^dbits ^ par_bit) != ohel_q);
    assign cnt_zero = (cnt == 19'd0);
    assign last     = (bits == n_bits - 4'd1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (!rx_s) state_d = START;
            START: if (cnt_zero) state_d = rx_s ? IDLE : DATA;
            DATA:  if (cnt_zero && last) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q      <= '0;
            cnt      <= '0;
            bits     <= '0;
            sr       <= '0;
            eight_q  <= 1'b0;
            pen_q    <= 1'b0;
            ohel_q   <= 1'b0;
            data_out <= '0;
            rxrdy    <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    eight_q <= eight;
                    pen_q   <= p_en;
                    ohel_q  <= ohel;
                    k_q     <= k_sel;
                    bits    <= '0;
                    cnt     <= (k_sel >> 1) - 19'd1;
                end
                START: cnt <= cnt_zero ? k_q - 19'd1 : cnt - 19'd1;
                DATA: begin
                    if (cnt_zero) begin
                        sr   <= {rx_s, sr[9:1]};
                        bits <= bits + 4'd1;
                        cnt  <= k_q - 19'd1;
                    end else begin
                        cnt <= cnt - 19'd1;
                    end
                end
                default: ;
            endcase

            if (state == DONE) begin
                data_out <= dbits;
                perr     <= perr_d;
                ferr     <= ~sr[9];
                rxrdy    <= 1'b1;
                ovf      <= clr ? 1'b0 : (ovf | rxrdy);
            end else if (clr) begin
                rxrdy <= 1'b0;
                perr  <= 1'b0;
                ferr  <= 1'b0;
                ovf   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_engine.sv
// Self-checking bench for rx_engine: vector table, corner sequences,
// and randomized frames against a frame-level reference model.
module tb_rx_engine;

    logic       clk = 1'b0;
    logic       rst, rx, eight, p_en, ohel, clr;
    logic [3:0] baud;
    logic [7:0] data_out;
    logic       rxrdy, perr, ferr, ovf;

    int nvec  = 0;
    int nfail = 0;
    bit rdy_m = 1'b0;
    bit ovf_m = 1'b0;

`ifdef RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    typedef struct {
        logic [3:0] baud;
        logic       e8, pe, oh;
        logic [7:0] d;
        logic       par, stp;
        logic [7:0] xd;
        logic       xp, xf;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    rx_engine dut (
        .clk(clk), .rst(rst), .rx(rx), .eight(eight), .p_en(p_en),
        .ohel(ohel), .baud(baud), .clr(clr), .data_out(data_out),
        .rxrdy(rxrdy), .perr(perr), .ferr(ferr), .ovf(ovf)
    );

    function automatic int kval(input logic [3:0] b);
        int kt [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604,
                        1736, 868, 434, 217, 109, 109, 109, 109, 109};
        return kt[b];
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic e8, pe, oh, input logic [7:0] d,
                                input logic par, stp, output logic [7:0] xd,
                                output logic xp, xf);
        int ones;
        xd   = e8 ? d : {1'b0, d[6:0]};
        ones = $countones(xd) + int'(par);
        xp   = pe && ((ones % 2) != int'(oh));
        xf   = !stp;
    endtask

    task automatic check_out(input string tag, input logic [7:0] xd,
                             input logic xp, xf);
        check({tag, ".data"}, data_out, xd);
        check({tag, ".perr"}, perr, xp);
        check({tag, ".ferr"}, ferr, xf);
        check({tag, ".rxrdy"}, rxrdy, rdy_m);
        check({tag, ".ovf"}, ovf, ovf_m);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        rdy_m = 1'b0;
        ovf_m = 1'b0;
    endtask

    task automatic done_cycle(input int k, input logic e8, pe, output int c);
        c = k / 2 + (8 + int'(e8) + int'(pe)) * k + 1 + SYNC;
    endtask

    // Drives one frame; the stop bit is cut short when low so the line
    // returns high well before any re-armed start check.
    task automatic send(input int k, input logic e8, pe, input logic [7:0] d,
                        input logic par, stp, input int clr_c, input bit scr,
                        output int lat);
        logic       b [0:11];
        int         n, total;
        logic [3:0] sb;
        logic       s8, sp, so;
        for (int i = 0; i < 12; i++) b[i] = 1'b1;
        n    = 8 + int'(e8) + int'(pe);
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        if (pe) b[8 + int'(e8)] = par;
        b[n]  = stp;
        total = n * k + (stp ? k : k / 2 + 8);
        lat   = -1;
        sb = baud; s8 = eight; sp = p_en; so = ohel;
        for (int c = 0; c < total; c++) begin
            rx  = b[c / k];
            clr = (c == clr_c);
            if (scr && c == 10) begin
                baud  = 4'($urandom);
                eight = 1'($urandom);
                p_en  = 1'($urandom);
                ohel  = 1'($urandom);
            end
            if (scr && c == n * k) begin
                baud = sb; eight = s8; p_en = sp; ohel = so;
            end
            @(posedge clk);
            #1;
            if (lat < 0 && rxrdy) lat = c + 1;
        end
        clr = 1'b0;
        rx  = 1'b1;
        repeat (k) @(posedge clk);
        #1;
        if (clr_c >= 0) ovf_m = 1'b0;
        else            ovf_m = ovf_m | rdy_m;
        rdy_m = 1'b1;
    endtask

    initial begin
        int         lat, dc, k;
        logic [7:0] xd, d;
        logic       xp, xf, e8, pe, oh, par, stp;

        tbl[0] = '{4'hB, 1'b1, 1'b1, 1'b0, 8'h65, 1'b0, 1'b1, 8'h65, 1'b0, 1'b0};
        tbl[1] = '{4'hB, 1'b0, 1'b0, 1'b0, 8'h65, 1'b0, 1'b1, 8'h65, 1'b0, 1'b0};
        tbl[2] = '{4'hB, 1'b1, 1'b1, 1'b1, 8'h65, 1'b0, 1'b1, 8'h65, 1'b1, 1'b0};
        tbl[3] = '{4'hB, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        tbl[4] = '{4'hA, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[5] = '{4'hB, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
        tbl[6] = '{4'hB, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};
        tbl[7] = '{4'hB, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[8] = '{4'hC, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[9] = '{4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

        rst = 1'b1; rx = 1'b1; clr = 1'b0;
        eight = 1'b1; p_en = 1'b0; ohel = 1'b0; baud = 4'hB;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset", {data_out, rxrdy, perr, ferr, ovf}, 12'h000);

        for (int i = 0; i < 10; i++) begin
            baud = tbl[i].baud; eight = tbl[i].e8;
            p_en = tbl[i].pe;   ohel  = tbl[i].oh;
            @(posedge clk);
            #1;
            send(kval(tbl[i].baud), tbl[i].e8, tbl[i].pe, tbl[i].d,
                 tbl[i].par, tbl[i].stp, -1, (i % 2) == 1, lat);
            check_out($sformatf("vec%0d", i), tbl[i].xd, tbl[i].xp, tbl[i].xf);
            if (i == 0) begin
                k = kval(4'hB);
                check("latency", (lat >= 10 * k + 55 + SYNC - 2) &&
                                 (lat <= 10 * k + 55 + SYNC + 2), 1);
            end
            pulse_clr();
            check($sformatf("vec%0d.clr", i), {rxrdy, perr, ferr, ovf}, 4'h0);
        end

        baud = 4'hB; eight = 1'b1; p_en = 1'b0; ohel = 1'b0;
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_out("false_start", 8'h00, 1'b0, 1'b0);

        k = kval(4'hB);
        send(k, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, -1, 1'b0, lat);
        check_out("ovf1", 8'h11, 1'b0, 1'b0);
        done_cycle(k, 1'b1, 1'b0, dc);
        send(k, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1, dc, 1'b0, lat);
        check_out("ovf_clr", 8'h22, 1'b0, 1'b0);
        send(k, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, -1, 1'b0, lat);
        check_out("ovf_set", 8'h33, 1'b0, 1'b0);

        p_en = 1'b1;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (k) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 rx = i[0];
            repeat (k) @(posedge clk);
        end
        #1 rst = 1'b1; rx = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_m = 1'b0; ovf_m = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check_out("rst_mid", 8'h00, 1'b0, 1'b0);
        send(k, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, -1, 1'b0, lat);
        check_out("after_rst", 8'hA5, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            baud = 4'($urandom_range(10, 15));
            e8 = 1'($urandom); pe = 1'($urandom); oh = 1'($urandom);
            d = 8'($urandom); par = 1'($urandom);
            stp = ($urandom_range(0, 4) != 0);
            eight = e8; p_en = pe; ohel = oh;
            if ($urandom_range(0, 1) == 1) pulse_clr();
            @(posedge clk);
            #1;
            k = kval(baud);
            dc = -1;
            if ($urandom_range(0, 4) == 0) done_cycle(k, e8, pe, dc);
            send(k, e8, pe, d, par, stp, dc, 1'($urandom), lat);
            expect_frame(e8, pe, oh, d, par, stp, xd, xp, xf);
            check_out($sformatf("rnd%0d", i), xd, xp, xf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
